// File: rtl/tron_pkg.sv
// Shared board geometry, colour codes and RAM address packing for the tron board
// writer (ram_update) and reader (board_scanner).
package tron_pkg;

  localparam int X_CELLS = 160;
  localparam int Y_CELLS = 120;
  localparam int XW      = 8;
  localparam int YW      = 7;
  localparam int CW      = 3;
  localparam int AW      = XW + YW;

  localparam logic [CW-1:0] COL_EMPTY = 3'b000;
  localparam logic [CW-1:0] COL_P1    = 3'b001;
  localparam logic [CW-1:0] COL_P2    = 3'b010;
  localparam logic [CW-1:0] COL_P3    = 3'b100;
  localparam logic [CW-1:0] COL_P4    = 3'b110;
  localparam logic [CW-1:0] COL_CRASH = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } scan_state_e;

  // x occupies the high bits so one board column is a contiguous block of rows
  function automatic logic [AW-1:0] pack_addr(input logic [XW-1:0] x,
                                              input logic [YW-1:0] y);
    return {x, y};
  endfunction

  function automatic logic [XW-1:0] addr_x(input logic [AW-1:0] addr);
    return addr[AW-1:YW];
  endfunction

  function automatic logic [YW-1:0] addr_y(input logic [AW-1:0] addr);
    return addr[YW-1:0];
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Column-major cell counter: y counts fastest, x steps when y wraps, and both
// wrap to zero after the last cell so the counter is ready for the next sweep.
module scan_counter
  import tron_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] X_MAX = XW'(X_CELLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(Y_CELLS - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (y_q == Y_MAX) begin
        y_d = '0;
        x_d = (x_q == X_MAX) ? '0 : x_q + 1'b1;
      end else begin
        y_d = y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/board_scanner.sv
// Sweeps the whole board RAM through a shared, arbitrated read port and streams
// one VGA plot per cell through a two-stage pipeline that tolerates grant stalls.
module board_scanner
  import tron_pkg::*;
(
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          start,
  output logic          rd_req,
  input  logic          rd_gnt,
  output logic [AW-1:0] rd_addr,
  input  logic [CW-1:0] rd_q,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot,
  output logic          busy,
  output logic          done
);

  scan_state_e   state_q, state_d;
  logic          pending_q, pending_d;

  logic          cnt_clr, cnt_en, cnt_last;
  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic          consume;

  logic          s1_valid_q, s1_valid_d;
  logic [XW-1:0] s1_x_q, s1_x_d;
  logic [YW-1:0] s1_y_q, s1_y_d;
  logic          s2_valid_q, s2_valid_d;
  logic [XW-1:0] s2_x_q, s2_x_d;
  logic [YW-1:0] s2_y_q, s2_y_d;
  logic [CW-1:0] s2_colour_q, s2_colour_d;

  scan_counter u_scan_counter (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .x     (cnt_x),
    .y     (cnt_y),
    .last  (cnt_last)
  );

  assign consume = (state_q == ST_SCAN) && rd_gnt;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          cnt_clr = 1'b1;
        end
      end
      ST_SCAN: begin
        if (start) pending_d = 1'b1;
        if (rd_gnt) begin
          cnt_en = 1'b1;
          if (cnt_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (start) pending_d = 1'b1;
        // stage 2 takes stage 1 unconditionally, so an empty stage 1 empties both
        if (!s1_valid_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        // a start landing in this cycle counts as pending; a second one is dropped
        if (pending_q || start) begin
          state_d   = ST_SCAN;
          cnt_clr   = 1'b1;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s1_valid_d  = consume;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    if (consume) begin
      s1_x_d = cnt_x;
      s1_y_d = cnt_y;
    end
    s2_valid_d  = s1_valid_q;
    s2_x_d      = s2_x_q;
    s2_y_d      = s2_y_q;
    s2_colour_d = s2_colour_q;
    if (s1_valid_q) begin
      s2_x_d      = s1_x_q;
      s2_y_d      = s1_y_q;
      s2_colour_d = rd_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_x_q      <= '0;
      s2_y_q      <= '0;
      s2_colour_q <= COL_EMPTY;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s2_valid_q  <= s2_valid_d;
      s2_x_q      <= s2_x_d;
      s2_y_q      <= s2_y_d;
      s2_colour_q <= s2_colour_d;
    end
  end

  assign rd_req     = (state_q == ST_SCAN);
  assign rd_addr    = pack_addr(cnt_x, cnt_y);
  assign vga_x      = s2_x_q;
  assign vga_y      = s2_y_q;
  assign vga_colour = s2_colour_q;
  assign vga_plot   = s2_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule
